// File: rtl/bus_master_sequencer_if.sv
// Requester-side and bus-manager-side signals of the round-robin bus master sequencer.
// master: the sequencer; slave: the requesters plus the bus manager facing it.
interface bus_master_sequencer_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    req_rw;
  logic [NUM_REQ*8-1:0]  req_addr;
  logic [NUM_REQ*16-1:0] req_wdata;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    done;
  logic                  err;
  logic [15:0]           rdata;
  logic                  as;
  logic                  rw;
  logic                  ds;
  logic [7:0]            addr;
  logic [15:0]           wdata;
  logic [15:0]           bus_rdata;
  logic                  da;

  modport master (
    input  req, req_rw, req_addr, req_wdata, bus_rdata, da,
    output gnt, done, err, rdata, as, rw, ds, addr, wdata
  );

  modport slave (
    output req, req_rw, req_addr, req_wdata, bus_rdata, da,
    input  gnt, done, err, rdata, as, rw, ds, addr, wdata
  );
endinterface

// File: rtl/bus_master_sequencer.sv
// Round-robin arbiter + as/ds/da transaction sequencer; done 4 cycles after req with a fast slave.
// Waits on da indefinitely unless BUS_TIMEOUT_EN bounds the STRB wait (err flags the timeout).
module bus_master_sequencer #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  bus_master_sequencer_if.master bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = PW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_STRB = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      own_q, own_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               as_q, as_d;
  logic               ds_q, ds_d;
  logic               rw_q, rw_d;
  logic [7:0]         addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic [15:0]        rdata_q, rdata_d;

  logic               found;
  logic [PW-1:0]      pick;
  logic [AW-1:0]      cand;
  logic [PW-1:0]      own_nxt;

`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]      cnt_q, cnt_d;
  logic               tmo_q, tmo_d;
  logic               err_q, err_d;
`endif

  // First pending request at or after the pointer, wrapping at NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + AW'(k);
      if (cand >= AW'(NUM_REQ)) begin
        cand = cand - AW'(NUM_REQ);
      end
      if (!found && bus.req[cand[PW-1:0]]) begin
        found = 1'b1;
        pick  = cand[PW-1:0];
      end
    end
  end

  assign own_nxt = (own_q == PW'(NUM_REQ - 1)) ? '0 : own_q + PW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    as_d    = as_q;
    ds_d    = ds_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          own_d       = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          as_d        = 1'b1;
          rw_d        = bus.req_rw[pick];
          addr_d      = bus.req_addr[{pick, 3'b000} +: 8];
          wdata_d     = bus.req_wdata[{pick, 4'b0000} +: 16];
          state_d     = S_ADDR;
        end
      end
      S_ADDR: begin
        ds_d    = 1'b1;
        state_d = S_STRB;
`ifdef BUS_TIMEOUT_EN
        cnt_d   = '0;
        tmo_d   = 1'b0;
`endif
      end
      S_STRB: begin
        if (bus.da) begin
          as_d    = 1'b0;
          ds_d    = 1'b0;
          if (rw_q) begin
            rdata_d = bus.bus_rdata;
          end
          state_d = S_REL;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          as_d    = 1'b0;
          ds_d    = 1'b0;
          tmo_d   = 1'b1;
          state_d = S_REL;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
`endif
      end
      S_REL: begin
        // Complete only once the manager has released da.
        if (!bus.da) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          ptr_d   = own_nxt;
          state_d = S_IDLE;
`ifdef BUS_TIMEOUT_EN
          err_d   = tmo_q;
          tmo_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      as_q    <= 1'b0;
      ds_q    <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      as_q    <= as_d;
      ds_q    <= ds_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.as    = as_q;
  assign bus.ds    = ds_q;
  assign bus.rw    = rw_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
endmodule

// File: tb/tb_bus_master_sequencer.sv
// Randomized bench for bus_master_sequencer: a round-robin / rdata reference model plus a
// reactive bus-manager that drives da with programmable delay and hold.
module tb_bus_master_sequencer;
  localparam int NR = 3;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_master_sequencer_if #(.NUM_REQ(NR)) bus();

  bus_master_sequencer #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [NR-1:0] g;
    logic          r;
    logic [7:0]    a;
    logic [15:0]   w;
    int            as_c;
    int            ds_c;
    int            ds_n;
    int            doff;
    int            lat;
    logic [NR-1:0] dn;
    logic          e;
    bit            bad_gnt;
    bit            unstable;
    bit            tmo;
  } obs_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          rr = 0;
  logic [15:0] exp_rdata = '0;

  // Reference arbitration: first requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [NR-1:0] rq, input int p);
    for (int k = 0; k < NR; k++) begin
      if (rq[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_done(input int w, input logic rd, input logic [15:0] rv, input bit timed);
    rr = (w + 1) % NR;
    if (rd && !timed) exp_rdata = rv;
  endtask

  task automatic apply_reset();
    bus.req = '0;
    bus.da  = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    rst       = 1'b1;
    rr        = 0;
    exp_rdata = '0;
  endtask

  task automatic set_req(input int i, input logic rwv, input logic [7:0] av, input logic [15:0] wv);
    bus.req_rw[i]            = rwv;
    bus.req_addr[i*8 +: 8]   = av;
    bus.req_wdata[i*16 +: 16] = wv;
    bus.req[i]               = 1'b1;
  endtask

  // Bus manager + monitor for one transaction. mode bits: 0 scramble req_* after grant,
  // 1 owner drops req after grant, 2 keep req on done, 3 raise da before ds.
  task automatic serve(input int dly, input int hold, input int mode, input logic [15:0] rv,
                       input int budget, output obs_t o);
    int cyc = 0;
    int hcnt = 0;
    bit got_as = 0;
    bit fin = 0;
    o.g = '0; o.r = 1'b0; o.a = '0; o.w = '0;
    o.as_c = 0; o.ds_c = 0; o.ds_n = 0; o.doff = 0; o.lat = 0;
    o.dn = '0; o.e = 1'b0; o.bad_gnt = 0; o.unstable = 0; o.tmo = 1;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if ($countones(bus.gnt) > 1) o.bad_gnt = 1;
      if (bus.done != '0) begin
        o.dn = bus.done; o.e = bus.err; o.lat = cyc; o.tmo = 0; fin = 1;
        if (!mode[2]) bus.req = bus.req & ~bus.done;
      end else begin
        if (bus.as && !got_as) begin
          got_as = 1; o.as_c = cyc;
          o.g = bus.gnt; o.r = bus.rw; o.a = bus.addr; o.w = bus.wdata;
          if (mode[0]) begin
            for (int k = 0; k < NR; k++) begin
              bus.req_rw[k]             = 1'($urandom);
              bus.req_addr[k*8 +: 8]    = 8'($urandom);
              bus.req_wdata[k*16 +: 16] = 16'($urandom);
            end
          end
          if (mode[1]) bus.req = bus.req & ~bus.gnt;
          if (mode[3]) begin bus.da = 1'b1; bus.bus_rdata = rv; end
        end else if (bus.as && (bus.rw !== o.r || bus.addr !== o.a || bus.wdata !== o.w)) begin
          o.unstable = 1;
        end
        if (bus.ds) begin
          o.ds_n++;
          if (o.ds_c == 0) o.ds_c = cyc;
          if (o.ds_n == dly + 1) begin bus.da = 1'b1; bus.bus_rdata = rv; end
        end else if (bus.da && o.ds_n > 0) begin
          if (hcnt == hold) begin bus.da = 1'b0; o.doff = cyc; end
          else hcnt++;
        end
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++; if ({bus.as, bus.ds, bus.rw} !== 3'b000) begin n_bad++; $display("FAIL reset_strobes: as/ds/rw=%b want 000", {bus.as, bus.ds, bus.rw}); end
    n_vec++; if ({bus.gnt, bus.done} !== '0) begin n_bad++; $display("FAIL reset_gnt_done: got %b want 0", {bus.gnt, bus.done}); end
    n_vec++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_vec++; if ({bus.addr, bus.wdata} !== 24'h0) begin n_bad++; $display("FAIL reset_addr_wdata: got %h want 0", {bus.addr, bus.wdata}); end
    n_vec++; if (bus.rdata !== 16'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0000", bus.rdata); end
  endtask

  task automatic test_read();
    obs_t o; int w; logic [NR-1:0] eg;
    set_req(0, 1'b1, 8'h3C, 16'h0000);
    w = rr_pick(bus.req, rr); eg = NR'(1) << w;
    serve(0, 0, 0, 16'hBEEF, 50, o);
    model_done(w, 1'b1, 16'hBEEF, 0);
    n_vec++; if (o.tmo !== 1'b0) begin n_bad++; $display("FAIL t1_no_done: timed out waiting for done"); end
    n_vec++; if (o.g !== eg) begin n_bad++; $display("FAIL t1_gnt: got %b want %b", o.g, eg); end
    n_vec++; if ({o.r, o.a} !== {1'b1, 8'h3C}) begin n_bad++; $display("FAIL t1_rw_addr: got %b/%h want 1/3c", o.r, o.a); end
    n_vec++; if (o.as_c !== 1 || o.ds_c !== 2) begin n_bad++; $display("FAIL t1_strobe_timing: as at %0d ds at %0d want 1 2", o.as_c, o.ds_c); end
    n_vec++; if (o.lat !== 4) begin n_bad++; $display("FAIL t1_latency: done at %0d want 4", o.lat); end
    n_vec++; if ({o.dn, o.e} !== {eg, 1'b0}) begin n_bad++; $display("FAIL t1_done_err: got %b/%b want %b/0", o.dn, o.e, eg); end
    n_vec++; if (bus.rdata !== exp_rdata) begin n_bad++; $display("FAIL t1_rdata: got %h want %h", bus.rdata, exp_rdata); end
    @(negedge clk);
    n_vec++; if ({bus.done, bus.gnt} !== '0) begin n_bad++; $display("FAIL t1_done_pulse: done/gnt=%b want 0", {bus.done, bus.gnt}); end
  endtask

  task automatic test_write();
    obs_t o; int w; logic [NR-1:0] eg;
    set_req(1, 1'b0, 8'h05, 16'h1234);
    w = rr_pick(bus.req, rr); eg = NR'(1) << w;
    serve(1, 1, 1, 16'hDEAD, 50, o);
    model_done(w, 1'b0, 16'hDEAD, 0);
    n_vec++; if (o.g !== eg) begin n_bad++; $display("FAIL t2_gnt: got %b want %b", o.g, eg); end
    n_vec++; if ({o.r, o.a, o.w} !== {1'b0, 8'h05, 16'h1234}) begin n_bad++; $display("FAIL t2_fields: got %b/%h/%h want 0/05/1234", o.r, o.a, o.w); end
    n_vec++; if (o.unstable !== 1'b0) begin n_bad++; $display("FAIL t2_stable: latched fields changed while as=1"); end
    n_vec++; if (o.dn !== eg) begin n_bad++; $display("FAIL t2_done: got %b want %b", o.dn, eg); end
    n_vec++; if (bus.rdata !== exp_rdata) begin n_bad++; $display("FAIL t2_rdata: got %h want %h", bus.rdata, exp_rdata); end
  endtask

  task automatic test_contention();
    obs_t o; int w; logic [NR-1:0] eg; logic [15:0] rv; logic rd;
    apply_reset();
    set_req(0, 1'b0, 8'h11, 16'hAAAA);
    set_req(1, 1'b1, 8'h22, 16'h5555);
    for (int t = 0; t < 4; t++) begin
      w = rr_pick(bus.req, rr); eg = NR'(1) << w; rd = bus.req_rw[w];
      rv = 16'($urandom);
      serve(0, 0, 4, rv, 50, o);
      model_done(w, rd, rv, 0);
      n_vec++; if (o.g !== eg) begin n_bad++; $display("FAIL t3_gnt_%0d: got %b want %b", t, o.g, eg); end
      n_vec++; if (o.bad_gnt !== 1'b0) begin n_bad++; $display("FAIL t3_onehot_%0d: multiple gnt bits seen", t); end
      n_vec++; if (o.lat !== 4) begin n_bad++; $display("FAIL t3_latency_%0d: done at %0d want 4", t, o.lat); end
    end
    bus.req = '0;
    n_vec++; if (bus.rdata !== exp_rdata) begin n_bad++; $display("FAIL t3_rdata: got %h want %h", bus.rdata, exp_rdata); end
  endtask

  task automatic test_slow_slave();
    obs_t o; int w; logic [NR-1:0] eg;
    set_req(2, 1'b1, 8'hA7, 16'h0F0F);
    w = rr_pick(bus.req, rr); eg = NR'(1) << w;
    serve(9, 3, 0, 16'h5A5A, 80, o);
    model_done(w, 1'b1, 16'h5A5A, 0);
    n_vec++; if (o.ds_n !== 10) begin n_bad++; $display("FAIL t4_ds_cycles: got %0d want 10", o.ds_n); end
    n_vec++; if (o.doff == 0 || o.lat !== o.doff + 1) begin n_bad++; $display("FAIL t4_done_after_da_low: done at %0d, da low at %0d", o.lat, o.doff); end
    n_vec++; if (o.dn !== eg) begin n_bad++; $display("FAIL t4_done: got %b want %b", o.dn, eg); end
    n_vec++; if (bus.rdata !== exp_rdata) begin n_bad++; $display("FAIL t4_rdata: got %h want %h", bus.rdata, exp_rdata); end
  endtask

  task automatic test_timeout();
    obs_t o; int w; logic [NR-1:0] eg; int dsc; bit saw_done;
    set_req(0, 1'b1, 8'h77, 16'h0000);
    w = rr_pick(bus.req, rr); eg = NR'(1) << w;
    dsc = 0; saw_done = 0;
`ifdef BUS_TIMEOUT_EN
    serve(-1, 0, 0, 16'hFFFF, 100, o);
    model_done(w, 1'b1, 16'hFFFF, 1);
    n_vec++; if (o.tmo !== 1'b0) begin n_bad++; $display("FAIL t5_no_done: timeout never completed"); end
    n_vec++; if (o.ds_n !== TO) begin n_bad++; $display("FAIL t5_ds_cycles: got %0d want %0d", o.ds_n, TO); end
    n_vec++; if ({o.dn, o.e} !== {eg, 1'b1}) begin n_bad++; $display("FAIL t5_done_err: got %b/%b want %b/1", o.dn, o.e, eg); end
    n_vec++; if (bus.rdata !== exp_rdata) begin n_bad++; $display("FAIL t5_rdata: got %h want %h", bus.rdata, exp_rdata); end
`else
    o.tmo = 0;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      if (bus.ds) dsc++;
      if (bus.done != '0) saw_done = 1;
    end
    n_vec++; if (dsc < 100) begin n_bad++; $display("FAIL t5_ds_held: ds high %0d cycles want >=100", dsc); end
    n_vec++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL t5_no_done: done pulsed with da stuck low"); end
    n_vec++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL t5_err: got %b want 0", bus.err); end
    apply_reset();
`endif
  endtask

  task automatic test_reset_in_strb();
    obs_t o; int w; logic [NR-1:0] eg; int c;
    set_req(0, 1'b0, 8'h10, 16'h1111);
    w = rr_pick(bus.req, rr); eg = NR'(1) << w;
    serve(0, 0, 0, 16'h0000, 50, o);
    model_done(w, 1'b0, 16'h0000, 0);
    n_vec++; if (o.dn !== eg) begin n_bad++; $display("FAIL t6_pre_done: got %b want %b", o.dn, eg); end
    set_req(1, 1'b1, 8'h20, 16'h0000);
    c = 0;
    while (!bus.ds && c < 20) begin @(negedge clk); c++; end
    n_vec++; if (bus.ds !== 1'b1) begin n_bad++; $display("FAIL t6_reach_strb: ds=%b want 1", bus.ds); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; rr = 0; exp_rdata = '0;
    n_vec++; if ({bus.as, bus.ds} !== 2'b00) begin n_bad++; $display("FAIL t6_strobes: as/ds=%b want 00", {bus.as, bus.ds}); end
    n_vec++; if ({bus.gnt, bus.done} !== '0) begin n_bad++; $display("FAIL t6_gnt_done: got %b want 0", {bus.gnt, bus.done}); end
    set_req(0, 1'b1, 8'h30, 16'h0000);
    w = rr_pick(bus.req, rr); eg = NR'(1) << w;
    serve(0, 0, 0, 16'hC0DE, 50, o);
    bus.req = '0;
    model_done(w, 1'b1, 16'hC0DE, 0);
    n_vec++; if (o.g !== eg) begin n_bad++; $display("FAIL t6_regrant: got %b want %b", o.g, eg); end
    n_vec++; if (o.dn !== eg) begin n_bad++; $display("FAIL t6_done: got %b want %b", o.dn, eg); end
    n_vec++; if (bus.rdata !== exp_rdata) begin n_bad++; $display("FAIL t6_rdata: got %h want %h", bus.rdata, exp_rdata); end
  endtask

  task automatic test_back_to_back();
    obs_t o; int w; logic [NR-1:0] eg; logic er; logic [7:0] ea; logic [15:0] ew, rv;
    int dly, hold, mode;
    for (int it = 0; it < 60; it++) begin
      for (int k = 0; k < NR; k++) begin
        if (!bus.req[k] && $urandom_range(0, 1) == 1)
          set_req(k, 1'($urandom), 8'($urandom), 16'($urandom));
      end
      if (bus.req == '0) set_req($urandom_range(0, NR - 1), 1'($urandom), 8'($urandom), 16'($urandom));
      w = rr_pick(bus.req, rr); eg = NR'(1) << w;
      er = bus.req_rw[w]; ea = bus.req_addr[w*8 +: 8]; ew = bus.req_wdata[w*16 +: 16];
      rv = 16'($urandom); dly = $urandom_range(0, 3); hold = $urandom_range(0, 2);
      mode = ($urandom_range(0, 1) << 3) | $urandom_range(0, 3);
      serve(dly, hold, mode, rv, 60, o);
      model_done(w, er, rv, 0);
      n_vec++; if (o.tmo !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_no_done: timed out", it); end
      n_vec++; if (o.g !== eg) begin n_bad++; $display("FAIL rnd%0d_gnt: got %b want %b", it, o.g, eg); end
      n_vec++; if ({o.r, o.a} !== {er, ea}) begin n_bad++; $display("FAIL rnd%0d_rw_addr: got %b/%h want %b/%h", it, o.r, o.a, er, ea); end
      if (!er) begin
        n_vec++; if (o.w !== ew) begin n_bad++; $display("FAIL rnd%0d_wdata: got %h want %h", it, o.w, ew); end
      end
      n_vec++; if (o.ds_n !== (mode[3] ? 1 : dly + 1)) begin n_bad++; $display("FAIL rnd%0d_ds_cycles: got %0d want %0d", it, o.ds_n, mode[3] ? 1 : dly + 1); end
      n_vec++; if ({o.dn, o.e} !== {eg, 1'b0}) begin n_bad++; $display("FAIL rnd%0d_done_err: got %b/%b want %b/0", it, o.dn, o.e, eg); end
      n_vec++; if (o.lat !== o.doff + 1) begin n_bad++; $display("FAIL rnd%0d_release: done at %0d, da low at %0d", it, o.lat, o.doff); end
      n_vec++; if (o.unstable || o.bad_gnt) begin n_bad++; $display("FAIL rnd%0d_integrity: unstable=%b multi_gnt=%b want 0 0", it, o.unstable, o.bad_gnt); end
      n_vec++; if (bus.rdata !== exp_rdata) begin n_bad++; $display("FAIL rnd%0d_rdata: got %h want %h", it, bus.rdata, exp_rdata); end
    end
    bus.req = '0;
  endtask

  initial begin
    rst           = 1'b0;
    bus.req       = '0;
    bus.req_rw    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.da        = 1'b0;
    bus.bus_rdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_contention();
    test_slow_slave();
    test_timeout();
    test_reset_in_strb();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
